// File: rtl/commit_queue.sv
// commit_queue -- in-order dual-retire commit buffer.
//
// Issue allocates scoreboard ids (sid) in program order; writeback fills
// entries by sid in any order; up to two completed entries retire per cycle
// from the head and drive registered architectural register-file writes.
// A retiring redirect flushes every younger entry.
//
// Optional build macro: COMMIT_TRACE_EN -- entries also keep pc/inst and the
// commitN_pc_o/commitN_inst_o trace outputs are registered with the commit.
// Without it the trace inputs are ignored and the trace outputs read 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alloc0/1_valid_i              issue slot requests (alloc1 only with alloc0)
//   alloc_ready_o                 >= 2 free entries and not in recovery cycle
//   alloc0/1_sid_o                sids granted this cycle (tail, tail+1)
//   instN_wb_*                    writeback result for entry instN_wb_sid_i
//   commitN_valid_o/we_o/rd_o/value_o   registered retire / regfile write
//   commit_redirect_o/_pc_o       registered redirect with fetch target
//   commitN_pc_o/inst_o           trace outputs
//
// Handshake: an allocation happens on a cycle where allocN_valid_i and
// alloc_ready_o are both 1; alloc_ready_o never depends on the valid inputs.
module commit_queue #(
  parameter int SID_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc0_valid_i,
  input  logic             alloc1_valid_i,
  output logic             alloc_ready_o,
  output logic [SID_W-1:0] alloc0_sid_o,
  output logic [SID_W-1:0] alloc1_sid_o,
  input  logic             inst0_wb_valid_i,
  input  logic [SID_W-1:0] inst0_wb_sid_i,
  input  logic [4:0]       inst0_wb_rd_i,
  input  logic [63:0]      inst0_wb_value_i,
  input  logic [63:0]      inst0_wb_pc_i,
  input  logic [31:0]      inst0_wb_inst_i,
  input  logic             inst0_wb_redirect_i,
  input  logic [63:0]      inst0_wb_redirect_pc_i,
  input  logic             inst1_wb_valid_i,
  input  logic [SID_W-1:0] inst1_wb_sid_i,
  input  logic [4:0]       inst1_wb_rd_i,
  input  logic [63:0]      inst1_wb_value_i,
  input  logic [63:0]      inst1_wb_pc_i,
  input  logic [31:0]      inst1_wb_inst_i,
  input  logic             inst1_wb_redirect_i,
  input  logic [63:0]      inst1_wb_redirect_pc_i,
  output logic             commit0_valid_o,
  output logic             commit0_we_o,
  output logic [4:0]       commit0_rd_o,
  output logic [63:0]      commit0_value_o,
  output logic             commit1_valid_o,
  output logic             commit1_we_o,
  output logic [4:0]       commit1_rd_o,
  output logic [63:0]      commit1_value_o,
  output logic             commit_redirect_o,
  output logic [63:0]      commit_redirect_pc_o,
  output logic [63:0]      commit0_pc_o,
  output logic [31:0]      commit0_inst_o,
  output logic [63:0]      commit1_pc_o,
  output logic [31:0]      commit1_inst_o
);

  localparam int DEPTH = 1 << SID_W;
  localparam logic [SID_W:0] CNT_ALLOC_MAX = (SID_W+1)'(DEPTH - 2);

  typedef logic [SID_W-1:0] sid_t;

  // Per-entry control state
  logic [DEPTH-1:0] ent_valid, ent_done, ent_redir;
  logic [DEPTH-1:0] valid_nx, done_nx, redir_nx;
  // Per-entry payload (no reset needed: only read once done is set)
  logic [4:0]       ent_rd    [DEPTH];
  logic [63:0]      ent_value [DEPTH];
  logic [63:0]      ent_rpc   [DEPTH];

  sid_t             head, tail;
  logic [SID_W:0]   count;

  sid_t             head_p1, tail_p1, head_nx;
  logic             ret0, ret1, flush;
  logic             acc0, acc1;
  logic             wb_hit0, wb_hit1;
  logic [SID_W:0]   count_nx;

  assign head_p1 = head + sid_t'(1);
  assign tail_p1 = tail + sid_t'(1);

  // Retire select: a redirect at head blocks the second slot so that a
  // redirecting instruction is always the last one retired in its cycle.
  assign ret0  = ent_valid[head] & ent_done[head];
  assign ret1  = ret0 & ~ent_redir[head] & ent_valid[head_p1] & ent_done[head_p1];
  assign flush = (ret0 & ent_redir[head]) | (ret1 & ent_redir[head_p1]);

  assign head_nx = head + sid_t'(ret0) + sid_t'(ret1);

  // The recovery cycle (redirect visible downstream) refuses issue so no
  // wrong-path instruction is ever accepted.
  assign alloc_ready_o = (count <= CNT_ALLOC_MAX) && !commit_redirect_o;
  assign alloc0_sid_o  = tail;
  assign alloc1_sid_o  = tail_p1;

  assign acc0 = alloc0_valid_i & alloc_ready_o;
  assign acc1 = acc0 & alloc1_valid_i;

  // Writebacks to entries that are not allocated are dropped.
  assign wb_hit0 = inst0_wb_valid_i & ent_valid[inst0_wb_sid_i];
  assign wb_hit1 = inst1_wb_valid_i & ent_valid[inst1_wb_sid_i];

  assign count_nx = count
                  + {{SID_W{1'b0}}, acc0} + {{SID_W{1'b0}}, acc1}
                  - {{SID_W{1'b0}}, ret0} - {{SID_W{1'b0}}, ret1};

  always_comb begin
    valid_nx = ent_valid;
    done_nx  = ent_done;
    redir_nx = ent_redir;
    if (wb_hit0) begin
      done_nx[inst0_wb_sid_i]  = 1'b1;
      redir_nx[inst0_wb_sid_i] = inst0_wb_redirect_i;
    end
    if (wb_hit1) begin
      done_nx[inst1_wb_sid_i]  = 1'b1;
      redir_nx[inst1_wb_sid_i] = inst1_wb_redirect_i;
    end
    if (ret0) valid_nx[head]    = 1'b0;
    if (ret1) valid_nx[head_p1] = 1'b0;
    // Newly allocated entries are never valid beforehand, so they cannot
    // collide with a retire or an accepted writeback.
    if (acc0) begin
      valid_nx[tail] = 1'b1;
      done_nx[tail]  = 1'b0;
    end
    if (acc1) begin
      valid_nx[tail_p1] = 1'b1;
      done_nx[tail_p1]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid            <= '0;
      ent_done             <= '0;
      ent_redir            <= '0;
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      commit0_valid_o      <= 1'b0;
      commit0_we_o         <= 1'b0;
      commit0_rd_o         <= '0;
      commit0_value_o      <= '0;
      commit1_valid_o      <= 1'b0;
      commit1_we_o         <= 1'b0;
      commit1_rd_o         <= '0;
      commit1_value_o      <= '0;
      commit_redirect_o    <= 1'b0;
      commit_redirect_pc_o <= '0;
    end else begin
      commit0_valid_o      <= ret0;
      commit0_we_o         <= ret0 && (ent_rd[head] != 5'd0);
      commit0_rd_o         <= ent_rd[head];
      commit0_value_o      <= ent_value[head];
      commit1_valid_o      <= ret1;
      commit1_we_o         <= ret1 && (ent_rd[head_p1] != 5'd0);
      commit1_rd_o         <= ent_rd[head_p1];
      commit1_value_o      <= ent_value[head_p1];
      commit_redirect_o    <= flush;
      commit_redirect_pc_o <= ret1 ? ent_rpc[head_p1] : ent_rpc[head];
      if (flush) begin
        // Everything younger than the redirect is wrong-path; this cycle's
        // allocations and writebacks are discarded with it.
        ent_valid <= '0;
        ent_done  <= '0;
        head      <= head_nx;
        tail      <= head_nx;
        count     <= '0;
      end else begin
        ent_valid <= valid_nx;
        ent_done  <= done_nx;
        ent_redir <= redir_nx;
        head      <= head_nx;
        tail      <= tail + sid_t'(acc0) + sid_t'(acc1);
        count     <= count_nx;
      end
    end
  end

  // Payload capture on accepted writebacks.
  always_ff @(posedge clk) begin
    if (wb_hit0 && !flush) begin
      ent_rd[inst0_wb_sid_i]    <= inst0_wb_rd_i;
      ent_value[inst0_wb_sid_i] <= inst0_wb_value_i;
      ent_rpc[inst0_wb_sid_i]   <= inst0_wb_redirect_pc_i;
    end
    if (wb_hit1 && !flush) begin
      ent_rd[inst1_wb_sid_i]    <= inst1_wb_rd_i;
      ent_value[inst1_wb_sid_i] <= inst1_wb_value_i;
      ent_rpc[inst1_wb_sid_i]   <= inst1_wb_redirect_pc_i;
    end
  end

`ifdef COMMIT_TRACE_EN
  logic [63:0] ent_pc   [DEPTH];
  logic [31:0] ent_inst [DEPTH];

  always_ff @(posedge clk) begin
    if (wb_hit0 && !flush) begin
      ent_pc[inst0_wb_sid_i]   <= inst0_wb_pc_i;
      ent_inst[inst0_wb_sid_i] <= inst0_wb_inst_i;
    end
    if (wb_hit1 && !flush) begin
      ent_pc[inst1_wb_sid_i]   <= inst1_wb_pc_i;
      ent_inst[inst1_wb_sid_i] <= inst1_wb_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit0_pc_o   <= '0;
      commit0_inst_o <= '0;
      commit1_pc_o   <= '0;
      commit1_inst_o <= '0;
    end else begin
      commit0_pc_o   <= ent_pc[head];
      commit0_inst_o <= ent_inst[head];
      commit1_pc_o   <= ent_pc[head_p1];
      commit1_inst_o <= ent_inst[head_p1];
    end
  end
`else
  assign commit0_pc_o   = '0;
  assign commit0_inst_o = '0;
  assign commit1_pc_o   = '0;
  assign commit1_inst_o = '0;

  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{inst0_wb_pc_i, inst0_wb_inst_i,
                                 inst1_wb_pc_i, inst1_wb_inst_i};
`endif

endmodule

// File: tb/tb_commit_queue.sv
module tb_commit_queue;

  localparam int SID_W = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        v;
    logic [2:0]  sid;
    logic [4:0]  rd;
    logic [63:0] val;
    logic        redir;
    logic [63:0] rpc;
  } wb_t;

  typedef struct {
    logic        a0, a1;
    wb_t         w0, w1;
    logic        rdy;
    logic [2:0]  sid0;
    logic        c0v, c0we;
    logic [4:0]  c0rd;
    logic [63:0] c0val;
    logic        c1v;
    logic [4:0]  c1rd;
    logic [63:0] c1val;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a0 = 1'b0, a1 = 1'b0;
  wb_t         w0 = '0, w1 = '0;
  logic [63:0] pc0 = '0, pc1 = '0;
  logic [31:0] in0 = '0, in1 = '0;

  logic        alloc_ready_o;
  logic [2:0]  alloc0_sid_o, alloc1_sid_o;
  logic        commit0_valid_o, commit0_we_o, commit1_valid_o, commit1_we_o;
  logic [4:0]  commit0_rd_o, commit1_rd_o;
  logic [63:0] commit0_value_o, commit1_value_o;
  logic        commit_redirect_o;
  logic [63:0] commit_redirect_pc_o;
  logic [63:0] commit0_pc_o, commit1_pc_o;
  logic [31:0] commit0_inst_o, commit1_inst_o;

  commit_queue #(.SID_W(SID_W)) dut (
    .clk(clk), .rst(rst),
    .alloc0_valid_i(a0), .alloc1_valid_i(a1),
    .alloc_ready_o(alloc_ready_o),
    .alloc0_sid_o(alloc0_sid_o), .alloc1_sid_o(alloc1_sid_o),
    .inst0_wb_valid_i(w0.v), .inst0_wb_sid_i(w0.sid), .inst0_wb_rd_i(w0.rd),
    .inst0_wb_value_i(w0.val), .inst0_wb_pc_i(pc0), .inst0_wb_inst_i(in0),
    .inst0_wb_redirect_i(w0.redir), .inst0_wb_redirect_pc_i(w0.rpc),
    .inst1_wb_valid_i(w1.v), .inst1_wb_sid_i(w1.sid), .inst1_wb_rd_i(w1.rd),
    .inst1_wb_value_i(w1.val), .inst1_wb_pc_i(pc1), .inst1_wb_inst_i(in1),
    .inst1_wb_redirect_i(w1.redir), .inst1_wb_redirect_pc_i(w1.rpc),
    .commit0_valid_o(commit0_valid_o), .commit0_we_o(commit0_we_o),
    .commit0_rd_o(commit0_rd_o), .commit0_value_o(commit0_value_o),
    .commit1_valid_o(commit1_valid_o), .commit1_we_o(commit1_we_o),
    .commit1_rd_o(commit1_rd_o), .commit1_value_o(commit1_value_o),
    .commit_redirect_o(commit_redirect_o), .commit_redirect_pc_o(commit_redirect_pc_o),
    .commit0_pc_o(commit0_pc_o), .commit0_inst_o(commit0_inst_o),
    .commit1_pc_o(commit1_pc_o), .commit1_inst_o(commit1_inst_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Program-order list of live sids plus per-sid completion data.
  int          order[$];
  logic        md   [DEPTH];
  logic        mr   [DEPTH];
  logic [4:0]  mrd  [DEPTH];
  logic [63:0] mval [DEPTH];
  logic [63:0] mrpc [DEPTH];
  int          m_tail;
  logic        m_rec;
  logic        e_c0v, e_c1v;
  logic [63:0] e_rpc;
  logic [69:0] exp_q[$];   // {we, rd, value} in retire order

  function automatic bit in_order(int s);
    foreach (order[k]) if (order[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return ((DEPTH - order.size()) >= 2) && !m_rec;
  endfunction

  task automatic model_reset();
    order.delete();
    for (int s = 0; s < DEPTH; s++) begin md[s] = 1'b0; mr[s] = 1'b0; end
    m_tail = 0; m_rec = 1'b0; e_c0v = 1'b0; e_c1v = 1'b0; e_rpc = '0;
    exp_q.delete();
  endtask

  task automatic model_wb(input wb_t w);
    if (w.v && in_order(int'(w.sid))) begin
      md[w.sid] = 1'b1; mr[w.sid] = w.redir; mrd[w.sid] = w.rd;
      mval[w.sid] = w.val; mrpc[w.sid] = w.rpc;
    end
  endtask

  task automatic model_step();
    bit rdy;
    int nret;
    int last;
    rdy  = m_ready();
    nret = 0;
    last = -1;
    if (order.size() > 0 && md[order[0]]) begin
      nret = 1;
      if (!mr[order[0]] && order.size() > 1 && md[order[1]]) nret = 2;
    end
    e_c0v = (nret >= 1);
    e_c1v = (nret == 2);
    for (int k = 0; k < nret; k++) begin
      last = order[k];
      exp_q.push_back({mrd[last] != 5'd0, mrd[last], mval[last]});
    end
    m_rec = (nret > 0) && mr[last];
    if (m_rec) begin
      e_rpc = mrpc[last];
      order.delete();
      for (int s = 0; s < DEPTH; s++) md[s] = 1'b0;
      m_tail = (last + 1) % DEPTH;
    end else begin
      model_wb(w0);
      model_wb(w1);
      repeat (nret) void'(order.pop_front());
      if (a0 && rdy) begin
        order.push_back(m_tail); md[m_tail] = 1'b0; m_tail = (m_tail + 1) % DEPTH;
        if (a1) begin
          order.push_back(m_tail); md[m_tail] = 1'b0; m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  // ---------------- driver / monitor ----------------
  task automatic check_commit(input string nm, input logic we, input logic [4:0] rd,
                              input logic [63:0] val);
    logic [69:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s unexpected retire actual rd=%0d value=%0h required=none", nm, rd, val);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_we"}, we, e[69]);
      chk({nm, "_rd"}, rd, e[68:64]);
      chk({nm, "_value"}, val, e[63:0]);
    end
  endtask

  // One clock: check combinational outputs, advance model, then check the
  // registered outputs on the following falling edge. Inputs are cleared.
  task automatic tick();
    chk("alloc_ready", alloc_ready_o, m_ready());
    chk("alloc0_sid", alloc0_sid_o, m_tail);
    chk("alloc1_sid", alloc1_sid_o, (m_tail + 1) % DEPTH);
    model_step();
    @(posedge clk);
    @(negedge clk);
    a0 = 1'b0; a1 = 1'b0; w0 = '0; w1 = '0;
    chk("commit0_valid", commit0_valid_o, e_c0v);
    chk("commit1_valid", commit1_valid_o, e_c1v);
    chk("commit_redirect", commit_redirect_o, m_rec);
    if (m_rec) chk("commit_redirect_pc", commit_redirect_pc_o, e_rpc);
    if (commit0_valid_o) check_commit("commit0", commit0_we_o, commit0_rd_o, commit0_value_o);
    if (commit1_valid_o) check_commit("commit1", commit1_we_o, commit1_rd_o, commit1_value_o);
  endtask

  task automatic do_reset();
    rst = 1'b1; a0 = 1'b0; a1 = 1'b0; w0 = '0; w1 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_commit0_valid", commit0_valid_o, 0);
    chk("rst_commit1_valid", commit1_valid_o, 0);
    chk("rst_commit0_we", commit0_we_o, 0);
    chk("rst_commit1_we", commit1_we_o, 0);
    chk("rst_redirect", commit_redirect_o, 0);
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_alloc0_sid", alloc0_sid_o, 0);
  endtask

  function automatic wb_t W(input int sid, input int rd, input logic [63:0] val,
                            input logic redir = 1'b0, input logic [63:0] rpc = '0);
    wb_t w;
    w.v = 1'b1; w.sid = 3'(sid); w.rd = 5'(rd); w.val = val; w.redir = redir; w.rpc = rpc;
    return w;
  endfunction

  function automatic vec_t mk(input logic va0, input logic va1, input wb_t vw0, input wb_t vw1,
                              input int sid0, input logic c0v, input logic c0we, input int c0rd,
                              input logic [63:0] c0val, input logic c1v, input int c1rd,
                              input logic [63:0] c1val);
    vec_t v;
    v.a0 = va0; v.a1 = va1; v.w0 = vw0; v.w1 = vw1; v.rdy = 1'b1; v.sid0 = 3'(sid0);
    v.c0v = c0v; v.c0we = c0we; v.c0rd = 5'(c0rd); v.c0val = c0val;
    v.c1v = c1v; v.c1rd = 5'(c1rd); v.c1val = c1val;
    return v;
  endfunction

  task automatic pick_wb(output wb_t w, input int avoid);
    int cand[$];
    int s;
    w = '0;
    if ($urandom_range(0, 2) == 0) return;
    if ($urandom_range(0, 9) == 0) begin
      s = $urandom_range(0, DEPTH - 1);
      if (in_order(s) || s == avoid) return;   // stray write to a free entry
    end else begin
      foreach (order[k]) if (!md[order[k]] && order[k] != avoid) cand.push_back(order[k]);
      if (cand.size() == 0) return;
      s = cand[$urandom_range(0, cand.size() - 1)];
    end
    w = W(s, $urandom_range(0, 31), {$urandom, $urandom},
          ($urandom_range(0, 7) == 0), {$urandom, $urandom});
  endtask

  vec_t vecs[23];

  initial begin
    wb_t nw;
    nw = '0;
    model_reset();
    do_reset();

    // ---- table: paired retire, rd=0, writeback to a free sid ----
    vecs[0]  = mk(1, 1, nw, nw, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, W(1, 5, 64'h11), nw, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, W(0, 3, 64'h22), nw, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, nw, nw, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, nw, nw, 2, 1, 1, 3, 64'h22, 1, 5, 64'h11);
    vecs[5]  = mk(1, 0, nw, nw, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, W(2, 0, 64'hdead), nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, nw, nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, nw, nw, 3, 1, 0, 0, 64'hdead, 0, 0, 0);
    vecs[9]  = mk(0, 0, W(5, 7, 64'h55), nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, nw, nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, nw, nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, nw, nw, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, nw, nw, 4, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, nw, nw, 5, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, W(3, 1, 64'h1), W(4, 2, 64'h2), 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, nw, nw, 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, nw, nw, 6, 1, 1, 1, 64'h1, 1, 2, 64'h2);
    vecs[18] = mk(0, 0, nw, nw, 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, nw, nw, 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, W(5, 9, 64'h99), nw, 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, nw, nw, 6, 0, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, nw, nw, 6, 1, 1, 9, 64'h99, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      a0 = vecs[i].a0; a1 = vecs[i].a1; w0 = vecs[i].w0; w1 = vecs[i].w1;
      chk($sformatf("vec%0d_ready", i), alloc_ready_o, vecs[i].rdy);
      chk($sformatf("vec%0d_sid0", i), alloc0_sid_o, vecs[i].sid0);
      chk($sformatf("vec%0d_c0v", i), commit0_valid_o, vecs[i].c0v);
      chk($sformatf("vec%0d_c1v", i), commit1_valid_o, vecs[i].c1v);
      if (vecs[i].c0v) begin
        chk($sformatf("vec%0d_c0we", i), commit0_we_o, vecs[i].c0we);
        chk($sformatf("vec%0d_c0rd", i), commit0_rd_o, vecs[i].c0rd);
        chk($sformatf("vec%0d_c0val", i), commit0_value_o, vecs[i].c0val);
      end
      if (vecs[i].c1v) begin
        chk($sformatf("vec%0d_c1rd", i), commit1_rd_o, vecs[i].c1rd);
        chk($sformatf("vec%0d_c1val", i), commit1_value_o, vecs[i].c1val);
      end
      tick();
    end

    // ---- full queue and pointer wrap ----
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a0 = 1'b1;
      chk("fill_sid", alloc0_sid_o, i);
      chk("fill_ready", alloc_ready_o, 1);
      tick();
    end
    a0 = 1'b1;
    chk("full_ready", alloc_ready_o, 0);
    tick();
    w0 = W(0, 4, 64'h40); w1 = W(1, 6, 64'h61);
    tick();
    tick();
    chk("drain_ready", alloc_ready_o, 1);
    chk("wrap_sid0", alloc0_sid_o, 7);
    chk("wrap_sid1", alloc1_sid_o, 0);
    a0 = 1'b1; a1 = 1'b1;
    tick();
    chk("after_wrap_sid0", alloc0_sid_o, 1);
    tick();

    // ---- redirect flush ----
    do_reset();
    a0 = 1'b1; a1 = 1'b1; tick();
    a0 = 1'b1; a1 = 1'b1; tick();
    a0 = 1'b1; tick();
    w0 = W(0, 1, 64'hA0); w1 = W(1, 2, 64'hA1); tick();
    w0 = W(3, 3, 64'hA3); w1 = W(4, 4, 64'hA4); tick();
    w0 = W(2, 6, 64'hA2, 1'b1, 64'h8000_1000); tick();
    a0 = 1'b1;          // flush cycle: this allocation must be discarded
    tick();
    chk("redir_c0v", commit0_valid_o, 1);
    chk("redir_c1v", commit1_valid_o, 0);
    chk("redir_flag", commit_redirect_o, 1);
    chk("redir_pc", commit_redirect_pc_o, 64'h8000_1000);
    chk("redir_ready", alloc_ready_o, 0);
    a0 = 1'b1;          // recovery cycle: refused
    tick();
    chk("post_redir_ready", alloc_ready_o, 1);
    chk("post_redir_sid", alloc0_sid_o, 3);
    a0 = 1'b1; tick();
    w0 = W(3, 7, 64'hB3); tick();
    tick();
    tick();

    // ---- reset with entries in flight ----
    do_reset();
    a0 = 1'b1; a1 = 1'b1; tick();
    a0 = 1'b1; a1 = 1'b1; tick();
    a0 = 1'b1; tick();
    w0 = W(0, 8, 64'hC0); w1 = W(1, 9, 64'hC1); tick();
    do_reset();
    a0 = 1'b1; tick();
    chk("post_rst_sid", alloc0_sid_o, 1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      a0 = ($urandom_range(0, 3) != 0);
      a1 = a0 && ($urandom_range(0, 1) == 1);
      pick_wb(w0, -1);
      pick_wb(w1, w0.v ? int'(w0.sid) : -1);
      pc0 = {$urandom, $urandom}; pc1 = {$urandom, $urandom};
      in0 = $urandom; in1 = $urandom;
      tick();
    end
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
